// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package bit_serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_ctrl_serial_fa_cell.sv
// One-bit full adder built from gate primitives.
module serial_fa_cell (
  input  logic lhs,
  input  logic rhs,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;
  logic gen;
  logic prop_c;

  xor g_prop  (prop,   lhs,  rhs);
  xor g_sum   (sum,    prop, cin);
  and g_gen   (gen,    lhs,  rhs);
  and g_pc    (prop_c, prop, cin);
  or  g_cout  (cout,   gen,  prop_c);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one operand bit per cycle through a single full-adder cell.
module bit_serial_adder_ctrl
  import bit_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] lhs_sh;
  logic [WIDTH-1:0] rhs_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  serial_fa_cell u_fa (
    .lhs  (lhs_sh[0]),
    .rhs  (rhs_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shifting, carry chain and final flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      lhs_sh <= '0;
      rhs_sh <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      lhs_sh <= lhs;
      rhs_sh <= rhs;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
      lhs_sh <= lhs_sh >> 1;
      rhs_sh <= rhs_sh >> 1;
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        cout_r <= fa_cout;
        // carry still holds the carry into the MSB on this cycle
        ovf_r  <= carry ^ fa_cout;
      end
    end
  end

  assign sum  = res_sh;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl (WIDTH=8).
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests  = 0;
  int failed = 0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .lhs   (lhs),
    .rhs   (rhs),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow from operand/result signs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    int unsigned full;
    logic [W:0]  f;
    logic        o;
    full = int'(a) + int'(b) + int'(c);
    f    = full[W:0];
    o    = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
    return {o, f};
  endfunction

  // One operation: start, optional operand scrambling and start noise while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit scramble, input bit noise, input string tag);
    logic [W+1:0] exp;
    logic [W-1:0] s_at;
    logic         co_at;
    logic         ov_at;
    int           busy_cnt;
    int           done_cnt;
    int           done_at;
    bit           both;
    exp      = ref_add(a, b, c);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    both     = 1'b0;
    s_at     = '0;
    co_at    = 1'b0;
    ov_at    = 1'b0;
    @(negedge clk);
    start = 1'b1; lhs = a; rhs = b; cin = c;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      lhs = W'($urandom); rhs = W'($urandom); cin = 1'($urandom);
    end
    for (int i = 0; i < W + 4; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) both = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i; s_at = sum; co_at = cout; ov_at = ovf;
        end
      end
      if (noise) start = (i >= 1 && i <= W);
    end
    start = 1'b0;
    check({tag, " done_at"}, done_at, W);
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " busy_cnt"}, busy_cnt, W);
    check({tag, " busy_and_done"}, 32'(both), 0);
    check({tag, " sum"}, 32'(s_at), 32'(exp[W-1:0]));
    check({tag, " cout"}, 32'(co_at), 32'(exp[W]));
    check({tag, " ovf"}, 32'(ov_at), 32'(exp[W+1]));
    check({tag, " sum_hold"}, 32'(sum), 32'(exp[W-1:0]));
  endtask

  initial begin
    int dcnt;
    bit bad_sum;
    rst = 1'b1; start = 1'b0; lhs = '0; rhs = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset sum",  32'(sum),  0);
    check("reset cout", 32'(cout), 0);
    check("reset ovf",  32'(ovf),  0);
    rst = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, "d05_03");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "dFF_01");
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "d7F_01");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "dFF_FF_1");
    do_op(8'h80, 8'h80, 1'b0, 1'b1, 1'b1, "d80_80_noise");

    // start held for 20 edges: exactly two operations
    @(negedge clk);
    start = 1'b1; lhs = 8'h10; rhs = 8'h20; cin = 1'b0;
    dcnt = 0; bad_sum = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (sum !== 8'h30) bad_sum = 1'b1;
      end
      if (i == 19) start = 1'b0;
    end
    check("held start done_cnt", dcnt, 2);
    check("held start sum", 32'(bad_sum), 0);

    // reset at the 4th RUN cycle aborts with no done pulse
    @(negedge clk);
    start = 1'b1; lhs = 8'h55; rhs = 8'h33; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort sum",  32'(sum),  0);
    check("abort cout", 32'(cout), 0);
    check("abort ovf",  32'(ovf),  0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort no activity", dcnt, 0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "after_abort");

    for (int n = 0; n < 1000; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
